// File: rtl/power_block_integrator.sv
// Block |x|^2 integrator: per-lane re^2+im^2 summed over a runtime-length block of beats,
// rounded at LSB_CUT and saturated to OUT_W. Define POWER_INT_RNE_EN for round-half-to-even.
module power_block_integrator #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 52,
    parameter int LANES   = 4,
    parameter int LSB_CUT = 11,
    parameter int MAX_ACC = 16,
    parameter int IDX_W   = 11,
    parameter int DC_SKIP = 2,
    localparam int ACC_W  = $clog2(MAX_ACC + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_re,
    input  logic [LANES*IN_W-1:0]  in_im,
    input  logic [IDX_W-1:0]       in_index,
    input  logic                   in_last,
    input  logic [ACC_W-1:0]       acc_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [IDX_W-1:0]       out_index,
    output logic [ACC_W-1:0]       out_count,
    output logic [LANES-1:0]       out_sat
);

    localparam int SQ_W  = 2 * IN_W;
    localparam int SUM_W = SQ_W + 1;
    localparam int AC_W  = SUM_W + ACC_W;
    localparam int SH_W  = AC_W - LSB_CUT + 1;
    localparam logic [ACC_W-1:0] MAX_LEN = ACC_W'(MAX_ACC);
    localparam logic [IDX_W-1:0] DC_LIM  = IDX_W'(DC_SKIP);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t            state_reg;
    logic [ACC_W-1:0]  len_reg;
    logic [ACC_W-1:0]  cnt_reg;
    logic [IDX_W-1:0]  index_reg;
    logic [ACC_W-1:0]  len_first;
    logic [ACC_W-1:0]  cnt_next;
    logic              close_beat;
    logic              stall;
    logic              fire;

    // Stage 0: captured beat plus block-control flags decided at acceptance
    logic                  s0_valid_reg, s0_load_reg, s0_close_reg, s0_skip_reg;
    logic [IDX_W-1:0]      s0_index_reg;
    logic [ACC_W-1:0]      s0_count_reg;
    logic [LANES*IN_W-1:0] s0_re_reg, s0_im_reg;

    logic             p1_valid_reg, p1_load_reg, p1_close_reg;
    logic [IDX_W-1:0] p1_index_reg;
    logic [ACC_W-1:0] p1_count_reg;
    logic             p2_valid_reg, p2_load_reg, p2_close_reg;
    logic [IDX_W-1:0] p2_index_reg;
    logic [ACC_W-1:0] p2_count_reg;
    logic             p3_valid_reg, p3_close_reg;
    logic [IDX_W-1:0] p3_index_reg;
    logic [ACC_W-1:0] p3_count_reg;

    logic             out_valid_reg;
    logic [IDX_W-1:0] out_index_reg;
    logic [ACC_W-1:0] out_count_reg;

    assign stall     = out_valid_reg & ~out_ready;
    assign in_ready  = ~stall;
    assign fire      = in_valid & ~stall;
    assign out_valid = out_valid_reg;
    assign out_index = out_index_reg;
    assign out_count = out_count_reg;

    always_comb begin
        if (acc_len == '0) begin
            len_first = ACC_W'(1);
        end else if (acc_len > MAX_LEN) begin
            len_first = MAX_LEN;
        end else begin
            len_first = acc_len;
        end
        cnt_next   = (state_reg == IDLE) ? ACC_W'(1) : cnt_reg + ACC_W'(1);
        close_beat = in_last | (cnt_next == ((state_reg == IDLE) ? len_first : len_reg));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            cnt_reg      <= '0;
            index_reg    <= '0;
            s0_valid_reg <= 1'b0;
            s0_load_reg  <= 1'b0;
            s0_close_reg <= 1'b0;
            s0_skip_reg  <= 1'b0;
            s0_index_reg <= '0;
            s0_count_reg <= '0;
            s0_re_reg    <= '0;
            s0_im_reg    <= '0;
        end else if (!stall) begin
            s0_valid_reg <= fire;
            if (fire) begin
                s0_re_reg    <= in_re;
                s0_im_reg    <= in_im;
                s0_skip_reg  <= (in_index < DC_LIM);
                s0_load_reg  <= (state_reg == IDLE);
                s0_close_reg <= close_beat;
                s0_count_reg <= cnt_next;
                s0_index_reg <= (state_reg == IDLE) ? in_index : index_reg;
                cnt_reg      <= cnt_next;
                if (state_reg == IDLE) begin
                    len_reg   <= len_first;
                    index_reg <= in_index;
                end
                state_reg <= close_beat ? IDLE : ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_reg  <= 1'b0;
            p1_load_reg   <= 1'b0;
            p1_close_reg  <= 1'b0;
            p1_index_reg  <= '0;
            p1_count_reg  <= '0;
            p2_valid_reg  <= 1'b0;
            p2_load_reg   <= 1'b0;
            p2_close_reg  <= 1'b0;
            p2_index_reg  <= '0;
            p2_count_reg  <= '0;
            p3_valid_reg  <= 1'b0;
            p3_close_reg  <= 1'b0;
            p3_index_reg  <= '0;
            p3_count_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_index_reg <= '0;
            out_count_reg <= '0;
        end else if (!stall) begin
            p1_valid_reg <= s0_valid_reg;
            p1_load_reg  <= s0_load_reg;
            p1_close_reg <= s0_close_reg;
            p1_index_reg <= s0_index_reg;
            p1_count_reg <= s0_count_reg;
            p2_valid_reg <= p1_valid_reg;
            p2_load_reg  <= p1_load_reg;
            p2_close_reg <= p1_close_reg;
            p2_index_reg <= p1_index_reg;
            p2_count_reg <= p1_count_reg;
            p3_valid_reg <= p2_valid_reg;
            p3_close_reg <= p2_close_reg;
            p3_index_reg <= p2_index_reg;
            p3_count_reg <= p2_count_reg;
            // Not stalled means any held result is being taken this edge
            out_valid_reg <= p3_valid_reg & p3_close_reg;
            if (p3_valid_reg && p3_close_reg) begin
                out_index_reg <= p3_index_reg;
                out_count_reg <= p3_count_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [SQ_W-1:0]  re_ext, im_ext;
            logic        [SQ_W-1:0]  re_sq, im_sq;
            logic        [SQ_W-1:0]  p1_sq_re_reg, p1_sq_im_reg;
            logic        [SUM_W-1:0] p2_sum_reg;
            logic        [AC_W-1:0]  acc_reg;
            logic        [OUT_W-1:0] out_lane_reg;
            logic                    sat_reg;
            logic                    inc;
            logic        [SH_W-1:0]  shifted;
            logic        [OUT_W-1:0] clamped;
            logic                    over;

            assign re_ext = SQ_W'($signed(s0_re_reg[gi*IN_W +: IN_W]));
            assign im_ext = SQ_W'($signed(s0_im_reg[gi*IN_W +: IN_W]));
            assign re_sq  = re_ext * re_ext;
            assign im_sq  = im_ext * im_ext;

`ifdef POWER_INT_RNE_EN
            // Exact half with an even kept LSB truncates
            assign inc = acc_reg[LSB_CUT-1] & ((|acc_reg[LSB_CUT-2:0]) | acc_reg[LSB_CUT]);
`else
            assign inc = acc_reg[LSB_CUT-1];
`endif
            assign shifted = {1'b0, acc_reg[AC_W-1:LSB_CUT]} + SH_W'(inc);

            if (SH_W > OUT_W) begin : g_clamp
                assign over    = |shifted[SH_W-1:OUT_W];
                assign clamped = over ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
            end else begin : g_noclamp
                assign over    = 1'b0;
                assign clamped = OUT_W'(shifted);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p1_sq_re_reg <= '0;
                    p1_sq_im_reg <= '0;
                    p2_sum_reg   <= '0;
                    acc_reg      <= '0;
                    out_lane_reg <= '0;
                    sat_reg      <= 1'b0;
                end else if (!stall) begin
                    if (s0_valid_reg) begin
                        p1_sq_re_reg <= s0_skip_reg ? '0 : re_sq;
                        p1_sq_im_reg <= s0_skip_reg ? '0 : im_sq;
                    end
                    if (p1_valid_reg) begin
                        p2_sum_reg <= {1'b0, p1_sq_re_reg} + {1'b0, p1_sq_im_reg};
                    end
                    // First beat of a block reloads so blocks can run back-to-back
                    if (p2_valid_reg) begin
                        acc_reg <= p2_load_reg ? AC_W'(p2_sum_reg)
                                               : acc_reg + AC_W'(p2_sum_reg);
                    end
                    if (p3_valid_reg && p3_close_reg) begin
                        out_lane_reg <= clamped;
                        sat_reg      <= over;
                    end
                end
            end

            assign out_data[gi*OUT_W +: OUT_W] = out_lane_reg;
            assign out_sat[gi]                 = sat_reg;
        end
    endgenerate

endmodule
